// File: rtl/fsa_edge_tracker_if.sv
// Frame-analysis result bus into the edge tracker and the tracked-position bus out of it.
interface fsa_edge_tracker_if #(
  parameter int unsigned C_IMG_WW = 12
);
  logic                ana_done;
  logic                lft_valid;
  logic [C_IMG_WW-1:0] lft_edge;
  logic                rt_valid;
  logic [C_IMG_WW-1:0] rt_edge;
  logic                lft_locked;
  logic [C_IMG_WW-1:0] lft_pos;
  logic                rt_locked;
  logic [C_IMG_WW-1:0] rt_pos;
  logic                gap_valid;
  logic [C_IMG_WW-1:0] gap;
  logic                upd;
  logic                timeout;

  // Producer of frame results / consumer of tracked positions.
  modport master (
    output ana_done, lft_valid, lft_edge, rt_valid, rt_edge,
    input  lft_locked, lft_pos, rt_locked, rt_pos, gap_valid, gap, upd, timeout
  );

  // The tracker itself.
  modport slave (
    input  ana_done, lft_valid, lft_edge, rt_valid, rt_edge,
    output lft_locked, lft_pos, rt_locked, rt_pos, gap_valid, gap, upd, timeout
  );
endinterface

// File: rtl/fsa_edge_tracker.sv
// Two independent edge trackers (left/right) that lock onto an edge once it has
// stayed within a tolerance over several consecutive frames, plus a gap output
// and a frame-arrival watchdog.
module fsa_edge_tracker #(
  parameter int unsigned C_IMG_WW     = 12,
  parameter int unsigned C_TOL        = 2,
  parameter int unsigned C_STABLE_NUM = 3,
  parameter int unsigned C_TIMEOUT    = 1000000
) (
  input logic               clk,
  input logic               reset,
  fsa_edge_tracker_if.slave bus
);

  localparam int unsigned DW        = C_IMG_WW + 1;
  localparam logic [23:0] TmoLast   = 24'(C_TIMEOUT - 1);
  localparam logic [3:0]  StableNum = 4'(C_STABLE_NUM);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StTrack  = 2'd1,
    StLocked = 2'd2
  } trk_state_e;

  // Index 0 = left side, index 1 = right side.
  logic [1:0]          valid;
  logic [C_IMG_WW-1:0] edge_in [2];
  logic [DW-1:0]       diff    [2];
  logic [1:0]          agree;

  trk_state_e          state_q [2];
  trk_state_e          state_d [2];
  logic [C_IMG_WW-1:0] ref_q   [2];
  logic [C_IMG_WW-1:0] ref_d   [2];
  logic [3:0]          cnt_q   [2];
  logic [3:0]          cnt_d   [2];
  logic [C_IMG_WW-1:0] pos_q   [2];
  logic [C_IMG_WW-1:0] pos_d   [2];

  logic [23:0]         tmo_cnt_q, tmo_cnt_d;
  logic                tmo_fire;
  logic                timeout_q;
  logic                upd_q;
  logic                gap_valid_q, gap_valid_d;
  logic [C_IMG_WW-1:0] gap_q, gap_d;

  assign valid      = {bus.rt_valid, bus.lft_valid};
  assign edge_in[0] = bus.lft_edge;
  assign edge_in[1] = bus.rt_edge;

  // Unsigned distance between the new edge and the reference, one bit wider so it never wraps.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      if (edge_in[s] >= ref_q[s]) begin
        diff[s] = {1'b0, edge_in[s]} - {1'b0, ref_q[s]};
      end else begin
        diff[s] = {1'b0, ref_q[s]} - {1'b0, edge_in[s]};
      end
      agree[s] = (diff[s] <= DW'(C_TOL));
    end
  end

  // Watchdog: cycles since the last frame, saturating; fires once at the terminal count.
  always_comb begin
    tmo_fire = !bus.ana_done && (tmo_cnt_q == TmoLast);
    if (bus.ana_done) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q == 24'hFF_FFFF) begin
      tmo_cnt_d = tmo_cnt_q;
    end else begin
      tmo_cnt_d = tmo_cnt_q + 24'd1;
    end
  end

  // Per-side tracker next state; a frame beats a coincident watchdog expiry.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      state_d[s] = state_q[s];
      ref_d[s]   = ref_q[s];
      cnt_d[s]   = cnt_q[s];
      pos_d[s]   = pos_q[s];
      if (bus.ana_done) begin
        unique case (state_q[s])
          StIdle: begin
            if (valid[s]) begin
              ref_d[s] = edge_in[s];
              cnt_d[s] = 4'd1;
              if (StableNum == 4'd1) begin
                state_d[s] = StLocked;
                pos_d[s]   = edge_in[s];
              end else begin
                state_d[s] = StTrack;
              end
            end
          end
          StTrack: begin
            if (!valid[s]) begin
              state_d[s] = StIdle;
              cnt_d[s]   = 4'd0;
            end else if (agree[s]) begin
              ref_d[s] = edge_in[s];
              cnt_d[s] = cnt_q[s] + 4'd1;
              if (cnt_q[s] + 4'd1 == StableNum) begin
                state_d[s] = StLocked;
                pos_d[s]   = edge_in[s];
              end
            end else begin
              ref_d[s] = edge_in[s];
              cnt_d[s] = 4'd1;
            end
          end
          StLocked: begin
            if (!valid[s]) begin
              state_d[s] = StIdle;
              cnt_d[s]   = 4'd0;
            end else if (agree[s]) begin
              ref_d[s] = edge_in[s];
              pos_d[s] = edge_in[s];
            end else begin
              state_d[s] = StTrack;
              ref_d[s]   = edge_in[s];
              cnt_d[s]   = 4'd1;
            end
          end
          default: begin
            state_d[s] = StIdle;
            cnt_d[s]   = 4'd0;
          end
        endcase
      end else if (tmo_fire) begin
        state_d[s] = StIdle;
        cnt_d[s]   = 4'd0;
      end
    end
  end

  // Gap from next-state values so it lands together with the refreshed positions.
  always_comb begin
    gap_valid_d = (state_d[0] == StLocked) && (state_d[1] == StLocked) &&
                  (pos_d[1] >= pos_d[0]);
    gap_d       = gap_valid_d ? (pos_d[1] - pos_d[0]) : '0;
  end

  // Tracker state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        state_q[s] <= StIdle;
        ref_q[s]   <= '0;
        cnt_q[s]   <= '0;
        pos_q[s]   <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        state_q[s] <= state_d[s];
        ref_q[s]   <= ref_d[s];
        cnt_q[s]   <= cnt_d[s];
        pos_q[s]   <= pos_d[s];
      end
    end
  end

  // Watchdog counter, sticky timeout flag, update strobe and gap registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q   <= '0;
      timeout_q   <= 1'b0;
      upd_q       <= 1'b0;
      gap_valid_q <= 1'b0;
      gap_q       <= '0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      upd_q       <= bus.ana_done;
      gap_valid_q <= gap_valid_d;
      gap_q       <= gap_d;
      if (bus.ana_done) begin
        timeout_q <= 1'b0;
      end else if (tmo_fire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.lft_locked = (state_q[0] == StLocked);
  assign bus.rt_locked  = (state_q[1] == StLocked);
  assign bus.lft_pos    = pos_q[0];
  assign bus.rt_pos     = pos_q[1];
  assign bus.gap_valid  = gap_valid_q;
  assign bus.gap        = gap_q;
  assign bus.upd        = upd_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: doc/fsa_edge_tracker.md
FSA_EDGE_TRACKER -- requirements
Module: fsa_edge_tracker

Interface
REQ-001 SHALL have parameter C_IMG_WW, default 12: edge/position width.
REQ-002 SHALL have parameter C_TOL, default 2: max |edge delta| between consecutive frames counted as agreeing.
REQ-003 SHALL have parameter C_STABLE_NUM, default 3, range 1..15: consecutive agreeing valid frames required to lock.
REQ-004 SHALL have parameter C_TIMEOUT, default 1000000: cycles without ana_done before the timeout fires, stored in a 24-bit counter.
REQ-005 SHALL have the following ports, clock and reset first:
- clk  input  1  sole clock; rising edge.
- reset  input  1  asynchronous, active-high reset.
- ana_done  input  1  one-cycle pulse; per-frame analysis results are valid.
- lft_valid  input  1  left edge found this frame.
- lft_edge  input  C_IMG_WW  left edge x.
- rt_valid  input  1  right edge found this frame.
- rt_edge  input  C_IMG_WW  right edge x.
- lft_locked  output  1  left side is in the LOCKED state.
- lft_pos  output  C_IMG_WW  last locked left position.
- rt_locked  output  1  right side is in the LOCKED state.
- rt_pos  output  C_IMG_WW  last locked right position.
- gap_valid  output  1  gap output is meaningful.
- gap  output  C_IMG_WW  rt_pos - lft_pos.
- upd  output  1  one-cycle pulse; outputs refreshed.
- timeout  output  1  sticky flag; no frame arrived within C_TIMEOUT cycles.

Function
REQ-006 SHALL run two independent, identical side trackers (left, right), each with:
- a state register: IDLE, TRACK or LOCKED;
- ref (C_IMG_WW bits);
- cnt (4 bits).
REQ-007 SHALL sample inputs only in cycles where ana_done=1; in all other cycles tracker state SHALL hold, except on a timeout (REQ-015).
REQ-008 SHALL compute d = |edge - ref| unsigned at C_IMG_WW+1 bits, with no wrap-around; "agree" means d <= C_TOL.
REQ-009 Tracker in IDLE, on ana_done:
- valid=1: ref<=edge, cnt<=1; go to LOCKED (pos<=edge) if C_STABLE_NUM=1, otherwise go to TRACK.
- valid=0: stay in IDLE.
REQ-010 Tracker in TRACK, on ana_done:
- valid=0: go to IDLE, cnt<=0.
- valid=1 and agree: ref<=edge, cnt<=cnt+1; if cnt+1=C_STABLE_NUM, go to LOCKED and pos<=edge.
- valid=1 and disagree: ref<=edge, cnt<=1, stay in TRACK.
REQ-011 Tracker in LOCKED, on ana_done:
- valid=0: go to IDLE; pos holds.
- valid=1 and agree: pos<=edge, ref<=edge, stay in LOCKED.
- valid=1 and disagree: go to TRACK, ref<=edge, cnt<=1; pos holds.
REQ-012 lft_locked/rt_locked SHALL be registered and equal (state==LOCKED), with 1-cycle latency from ana_done.
REQ-013 Gap output, registered in the same cycle as the positions update, computed from next-state values:
- when both sides are locked and rt_pos >= lft_pos: gap_valid=1, gap=rt_pos-lft_pos;
- otherwise: gap_valid=0, gap=0.
REQ-014 upd SHALL pulse 1 cycle, exactly one cycle after each accepted ana_done, coincident with the refreshed outputs.
REQ-015 Timeout counter:
- counts cycles since the last ana_done, cleared to 0 on ana_done, saturating;
- on reaching C_TIMEOUT-1: both trackers go to IDLE with cnt=0; lft_locked, rt_locked and gap_valid go to 0; gap goes to 0; positions hold;
- timeout<=1 on that event and stays 1 until the next ana_done clears it (cleared in the upd cycle).
REQ-016 If ana_done coincides with the timeout terminal count, ana_done SHALL take priority and timeout SHALL NOT fire.
REQ-017 Back-to-back ana_done pulses on consecutive cycles SHALL each be processed, with no loss.

Reset
REQ-018 While reset=1, asynchronously:
- all outputs = 0;
- both trackers in IDLE with ref=0, cnt=0;
- timeout counter = 0.
REQ-019 Deasserting reset SHALL NOT produce an upd pulse; tracking SHALL resume at the first ana_done after release.

Verification (bench params: C_TOL=2, C_STABLE_NUM=3, C_TIMEOUT=64)
REQ-020 Lock: 3 frames with lft_valid=1, lft_edge=100,101,102 -> after the 3rd ana_done+1: lft_locked=1, lft_pos=102, upd pulses once per frame.
REQ-021 Break: locked at 102, next frame edge=110 -> lft_locked=0, lft_pos=102; then 111,112 -> relocked, lft_pos=112.
REQ-022 Gap: both sides locked, lft=100, rt=300 -> gap_valid=1, gap=200; then rt locks at 50 -> gap_valid=0, gap=0.
REQ-023 Timeout:
- both sides locked, no ana_done for 64 cycles -> timeout=1, both locked=0, gap_valid=0;
- next ana_done -> timeout=0.
- Also: ana_done exactly at count 63 -> timeout stays 0.
REQ-024 Edge extremes: ref=4095, edge=0 -> disagree (d=4095); ref=0, edge=2 -> agree.
REQ-025 Reset mid-operation: reset asserted while both sides are locked -> all outputs 0 within the same cycle; first post-reset ana_done with valid=1 -> TRACK, cnt=1.
